// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU:
//   - 4-bit opcode constants
//   - FSM state enumeration for the start/busy/done controller
//   - is_iterative(): true for opcodes handled by the multi-cycle unit
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef logic [3:0] opcode_t;

   localparam opcode_t OP_AND   = 4'b0000;
   localparam opcode_t OP_OR    = 4'b0001;
   localparam opcode_t OP_ADD   = 4'b0010;
   localparam opcode_t OP_SUB   = 4'b0110;
   localparam opcode_t OP_SLT   = 4'b0111;
   localparam opcode_t OP_SLTU  = 4'b1000;
   localparam opcode_t OP_MULTU = 4'b1001;
   localparam opcode_t OP_DIVU  = 4'b1010;
   localparam opcode_t OP_NOR   = 4'b1100;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Opcodes that take the one-bit-per-clock path. A DIVU with a zero
   // divisor is still classified here; the controller short-circuits it.
   function automatic logic is_iterative(input opcode_t op);
      return (op == OP_MULTU) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
// Iterative unsigned multiply / divide datapath, one bit per clock.
//   MULTU: shift-add, LSB first, on the {acc_hi, acc_lo} accumulator
//          (acc_lo starts as the multiplier and is shifted out right).
//   DIVU : restoring shift-subtract, MSB first; acc_hi is the partial
//          remainder, acc_lo starts as the dividend and collects quotient bits.
// Ports:
//   clk, reset      clock, async active-high reset
//   load            latch op/a/b, clear accumulator, counter <= WIDTH
//   step            perform one iteration (counter decrements)
//   op, a, b        operation and operands, sampled on load
//   last            counter == 1: the coming step is the final one
//   nxt_hi, nxt_lo  accumulator value after the current step; the owner
//                   registers these on the final step to obtain the result
// -----------------------------------------------------------------------------
module mdu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  opcode_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opnd;     // multiplicand or divisor
   logic [CW-1:0]    cnt;
   logic             is_div;

   logic [WIDTH:0]   sum;      // multiply: hi half plus multiplicand, with carry
   logic [WIDTH:0]   shifted;  // divide: remainder shifted left, next dividend bit in
   logic [WIDTH:0]   diff;     // divide: trial subtraction, diff[WIDTH] = borrow

   // NOTE: every combinational output gets a default before any branch, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      nxt_hi  = acc_hi;
      nxt_lo  = acc_lo;
      sum     = '0;
      shifted = '0;
      diff    = '0;
      if (is_div) begin
         shifted = {acc_hi, acc_lo[WIDTH-1]};
         diff    = shifted - {1'b0, opnd};
         // Partial remainder is always below the divisor, so shifted fits in
         // WIDTH+1 bits and the borrow alone decides restore vs. keep.
         if (!diff[WIDTH]) begin
            nxt_hi = diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            nxt_hi = shifted[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
         nxt_hi = sum[WIDTH:1];
         nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   assign last = (cnt == CW'(1));

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
         cnt    <= '0;
         is_div <= 1'b0;
      end else if (load) begin
         acc_hi <= '0;
         acc_lo <= a;
         opnd   <= b;
         cnt    <= CW'(WIDTH);
         is_div <= (op == OP_DIVU);
      end else if (step && (cnt != '0)) begin
         acc_hi <= nxt_hi;
         acc_lo <= nxt_lo;
         cnt    <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Registered ALU with start/busy/done handshake. Single-cycle logic and
// arithmetic ops finish one edge after start; MULTU and DIVU run for WIDTH
// edges in mdu_iter and return a double-width result on result_hi/result_lo.
// Ports:
//   clk, reset            clock, async active-high reset
//   start, op, a, b       request and operands, sampled while busy = 0
//   result_lo             result / product low half / quotient
//   result_hi             product high half / remainder, 0 for single-cycle ops
//   zero                  result_lo == 0, registered with the result
//   busy                  iterative op in progress
//   done                  one-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   state_t state, nstate;

   logic             mdu_load;
   logic             mdu_step;
   logic             mdu_last;
   logic [WIDTH-1:0] mdu_hi;
   logic [WIDTH-1:0] mdu_lo;

   logic             wr_single;
   logic             wr_iter;
   logic [WIDTH-1:0] alu_lo;
   logic [WIDTH-1:0] alu_hi;

   mdu_iter #(.WIDTH(WIDTH)) u_mdu (
      .clk    (clk),
      .reset  (reset),
      .load   (mdu_load),
      .step   (mdu_step),
      .op     (op),
      .a      (a),
      .b      (b),
      .last   (mdu_last),
      .nxt_hi (mdu_hi),
      .nxt_lo (mdu_lo)
   );

   // Single-cycle result. DIVU lands here only with a zero divisor.
   always_comb begin
      alu_lo = '0;
      alu_hi = '0;
      case (op)
         OP_AND:  alu_lo = a & b;
         OP_OR:   alu_lo = a | b;
         OP_ADD:  alu_lo = a + b;
         OP_SUB:  alu_lo = a - b;
         OP_NOR:  alu_lo = ~(a | b);
         OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_DIVU: begin
            alu_lo = '1;
            alu_hi = a;
         end
         default: alu_lo = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= nstate;
   end

   always_comb begin
      nstate    = state;
      mdu_load  = 1'b0;
      mdu_step  = 1'b0;
      wr_single = 1'b0;
      wr_iter   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (is_iterative(op) && !((op == OP_DIVU) && (b == '0))) begin
                  mdu_load = 1'b1;
                  nstate   = ST_RUN;
               end else begin
                  wr_single = 1'b1;
               end
            end
         end
         ST_RUN: begin
            mdu_step = 1'b1;
            if (mdu_last) begin
               wr_iter = 1'b1;
               nstate  = ST_IDLE;
            end
         end
         default: nstate = ST_IDLE;
      endcase
   end

   // busy comes straight from the state register, so it carries no
   // combinational path from the inputs.
   assign busy = (state == ST_RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_lo <= '0;
         result_hi <= '0;
         zero      <= 1'b1;
         done      <= 1'b0;
      end else begin
         done <= wr_single | wr_iter;
         if (wr_single) begin
            result_lo <= alu_lo;
            result_hi <= alu_hi;
            zero      <= (alu_lo == '0);
         end else if (wr_iter) begin
            result_lo <= mdu_lo;
            result_hi <= mdu_hi;
            zero      <= (mdu_lo == '0);
         end
      end
   end

endmodule
